bcd_time_cnt: RTL

Parametrised cascaded BCD up/down time counter: successor to the fixed five-digit stopwatch counter in the stopwatch datapath. The digit count and per-digit modulus are generics. End-of-range behaviour is selectable: stop at the limit, or wrap around. An optional lap register captures the running count without disturbing it. The block sits between the stopwatch control FSM (which drives `ce`, `load`, `up`, `lap`) and the display multiplexer.

---
 rtl/bcd_time_cnt_if.sv | 25 ++
 rtl/bcd_time_cnt.sv | 98 +++++++++
 2 files changed

// File: rtl/bcd_time_cnt_if.sv
// Control/data bundle between the stopwatch control FSM (master) and the
// cascaded BCD time counter (slave).
interface bcd_time_cnt_if #(
  parameter int NUM_DIGITS = 5
);
  logic                    ce;
  logic                    load;
  logic                    up;
  logic                    lap;
  logic [4*NUM_DIGITS-1:0] q;
  logic [4*NUM_DIGITS-1:0] count;
  logic [4*NUM_DIGITS-1:0] lap_count;
  logic                    at_limit;
  logic                    wrapped;

  modport master (
    output ce, load, up, lap, q,
    input  count, lap_count, at_limit, wrapped
  );

  modport slave (
    input  ce, load, up, lap, q,
    output count, lap_count, at_limit, wrapped
  );
endinterface

// File: rtl/bcd_time_cnt.sv
// Parametrised cascaded BCD up/down time counter with clamped load, stop/wrap
// end-of-range and an optional lap register (enabled by BCD_TIME_CNT_LAP_EN).
module bcd_time_cnt #(
  parameter int                      NUM_DIGITS = 5,
  parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX  = 20'h95999,
  parameter bit                      WRAP       = 1'b0
) (
  input logic          clk,
  input logic          clr,
  bcd_time_cnt_if.slave cnt_if
);
  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0]          count_q, count_d;
  logic                  wrapped_q, wrapped_d;
  logic [NUM_DIGITS-1:0] term;
  logic [NUM_DIGITS-1:0] step;
  logic                  advance;
  logic                  at_limit;
  logic                  hold_at_limit;

  assign advance = cnt_if.ce & ~cnt_if.load;

  always_comb begin
    term = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      term[i] = cnt_if.up ? (count_q[4*i +: 4] == DIGIT_MAX[4*i +: 4])
                          : (count_q[4*i +: 4] == 4'd0);
    end
  end

  assign at_limit = &term;

  // Carry enable built with a running AND so every digit resolves in one edge.
  always_comb begin
    logic chain;
    chain = advance;
    step  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step[i] = chain;
      chain   = chain & term[i];
    end
  end

  assign hold_at_limit = at_limit & advance & ~WRAP;

  always_comb begin
    count_d   = count_q;
    wrapped_d = WRAP & at_limit & advance;
    if (cnt_if.load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        count_d[4*i +: 4] = (cnt_if.q[4*i +: 4] > DIGIT_MAX[4*i +: 4]) ?
                            DIGIT_MAX[4*i +: 4] : cnt_if.q[4*i +: 4];
      end
    end else if (!hold_at_limit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (step[i]) begin
          if (cnt_if.up) begin
            count_d[4*i +: 4] = term[i] ? 4'd0 : count_q[4*i +: 4] + 4'd1;
          end else begin
            count_d[4*i +: 4] = term[i] ? DIGIT_MAX[4*i +: 4] : count_q[4*i +: 4] - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign cnt_if.count    = count_q;
  assign cnt_if.wrapped  = wrapped_q;
  assign cnt_if.at_limit = at_limit;

`ifdef BCD_TIME_CNT_LAP_EN
  logic [W-1:0] lap_q, lap_d;

  assign lap_d = cnt_if.lap ? count_q : lap_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) lap_q <= '0;
    else     lap_q <= lap_d;
  end

  assign cnt_if.lap_count = lap_q;
`else
  logic unused_lap;
  assign unused_lap       = cnt_if.lap;
  assign cnt_if.lap_count = '0;
`endif
endmodule
